random_pe_top: RTL and testbench

- Array of X*Y traffic-generator processing elements that drive the PE ports of the mesh NoC top.
- Each PE injects numPackets packets into the NoC, with addresses set by a selectable traffic pattern and a programmable injection rate.
- Each PE counts the packets the NoC delivers to it.
- Top-level done flag and per-PE receive counters feed the throughput/efficiency measurement bench.

---
 rtl/random_pe_top.sv | 135 +++++++++++++
 tb/tb_random_pe_top.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_pe_top.sv
// rtl/random_pe_top.sv - X*Y traffic-generator PEs driving a mesh NoC, with per-PE receive counters.
// Optional macro PE_DEST_CHECK_EN: drop and report delivered packets whose dest field is not this PE.
module random_pe_top #(
   parameter int    X          = 4,
   parameter int    Y          = 4,
   parameter int    data_width = 256,
   parameter int    x_size     = 2,
   parameter int    y_size     = 2,
   parameter int    numPackets = 1000,
   parameter int    rate       = 1,
   parameter string pat        = "RANDOM"
) (
   input  logic                                       clk,
   input  logic                                       rstn,
   output logic [X*Y-1:0]                             r_valid_pe,
   output logic [(x_size+y_size+data_width)*X*Y-1:0]  r_data_pe,
   input  logic [X*Y-1:0]                             r_ready_pe,
   input  logic [X*Y-1:0]                             w_valid_pe,
   input  logic [(x_size+y_size+data_width)*X*Y-1:0]  w_data_pe,
   output logic                                       done,
   input  logic                                       start,
   input  logic [X*Y-1:0]                             enableSend,
   output logic [32*X*Y-1:0]                          receiveCount
);

   localparam int TW  = x_size + y_size + data_width;
   localparam int AW  = x_size + y_size;
   localparam int NPE = X * Y;
   localparam logic [31:0] NUM     = 32'(numPackets);
   localparam logic [31:0] RATE_M1 = 32'(rate - 1);

   logic [NPE-1:0] pe_done;

   for (genvar i = 0; i < NPE; i++) begin : g_pe
      logic [31:0]           sent;
      logic [31:0]           rate_cnt;
      logic [31:0]           seq_next;
      logic [15:0]           lfsr;
      logic [15:0]           lfsr_adv;
      logic                  valid;
      logic                  xfer;
      logic                  present;
      logic [TW-1:0]         data;
      logic [AW-1:0]         dest;
      logic [data_width-1:0] payload;
      logic [31:0]           rc;
      logic                  hit;

      assign xfer     = valid & r_ready_pe[i];
      assign lfsr_adv = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      assign seq_next = xfer ? sent + 32'd1 : sent;
      // A new packet may replace the one leaving this very cycle, giving back-to-back issue.
      assign present  = start & enableSend[i] & (rate_cnt == 32'd0) & (~valid | xfer)
                        & (seq_next < NUM);

      if (pat == "NEIGHBOR") begin : g_nb
         localparam int XI = i % X;
         localparam int YI = i / X;
         assign dest = {y_size'(YI), x_size'((XI + 1) % X)};
      end else begin : g_rnd
         logic [AW-1:0] cand;
         // The address must come from the LFSR state the packet will be issued with.
         assign cand = xfer ? lfsr_adv[AW-1:0] : lfsr[AW-1:0];
         assign dest = (cand == AW'(i)) ? AW'((i + 1) % NPE) : cand;
      end

      always_comb begin
         payload        = '0;
         payload[31:0]  = seq_next;
         payload[63:32] = 32'(i);
      end

      always_ff @(posedge clk) begin
         if (!rstn) begin
            valid    <= 1'b0;
            data     <= '0;
            sent     <= '0;
            rate_cnt <= '0;
            lfsr     <= 16'(i + 1);
         end else begin
            if (xfer) begin
               sent <= sent + 32'd1;
               lfsr <= lfsr_adv;
            end
            if (present) begin
               valid    <= 1'b1;
               data     <= {payload, dest};
               rate_cnt <= RATE_M1;
            end else begin
               if (xfer)
                  valid <= 1'b0;
               if (rate_cnt != 32'd0)
                  rate_cnt <= rate_cnt - 32'd1;
            end
         end
      end

`ifdef PE_DEST_CHECK_EN
      assign hit = w_valid_pe[i] & (w_data_pe[i*TW +: AW] == AW'(i));

      always_ff @(posedge clk) begin
         if (rstn && w_valid_pe[i] && !hit)
            $display("random_pe_top: PE %0d got misrouted packet from source %0d",
                     i, w_data_pe[i*TW + AW + 32 +: 32]);
      end
`else
      assign hit = w_valid_pe[i];
`endif

      always_ff @(posedge clk) begin
         if (!rstn)
            rc <= '0;
         else if (hit)
            rc <= rc + 32'd1;
      end

      assign pe_done[i]               = ~enableSend[i] | (sent == NUM);
      assign r_valid_pe[i]            = valid;
      assign r_data_pe[i*TW +: TW]    = data;
      assign receiveCount[i*32 +: 32] = rc;
   end

`ifndef PE_DEST_CHECK_EN
   logic unused_w_data;
   assign unused_w_data = ^w_data_pe;
`endif

   always_ff @(posedge clk) begin
      if (!rstn)
         done <= 1'b0;
      else if (&pe_done)
         done <= 1'b1;
   end

endmodule

// File: tb/tb_random_pe_top.sv
// tb/tb_random_pe_top.sv - randomized self-checking bench for random_pe_top on a 2x2 mesh.
module tb_random_pe_top;
   localparam int TW = 66;
   localparam int NP = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstn;
   logic            start_a, start_b;
   logic [3:0]      en_a, en_b, rdy_a, rdy_b, wv_a, wv_b, rv_a, rv_b;
   logic [4*TW-1:0] wd_a, wd_b, rd_a, rd_b;
   logic            done_a, done_b;
   logic [127:0]    rc_a, rc_b;

   random_pe_top #(.X(2), .Y(2), .data_width(64), .x_size(1), .y_size(1),
                   .numPackets(NP), .rate(1), .pat("RANDOM")) dut_a (
      .clk(clk), .rstn(rstn), .r_valid_pe(rv_a), .r_data_pe(rd_a), .r_ready_pe(rdy_a),
      .w_valid_pe(wv_a), .w_data_pe(wd_a), .done(done_a), .start(start_a),
      .enableSend(en_a), .receiveCount(rc_a));

   random_pe_top #(.X(2), .Y(2), .data_width(64), .x_size(1), .y_size(1),
                   .numPackets(NP), .rate(3), .pat("NEIGHBOR")) dut_b (
      .clk(clk), .rstn(rstn), .r_valid_pe(rv_b), .r_data_pe(rd_b), .r_ready_pe(rdy_b),
      .w_valid_pe(wv_b), .w_data_pe(wd_b), .done(done_b), .start(start_b),
      .enableSend(en_b), .receiveCount(rc_b));

   int errors = 0;
   int checks = 0;
   int m_sent[4];
   int m_recv[4];
   logic [15:0] m_lfsr[4];
   int q[4][$];

   function automatic logic [TW-1:0] exp_pkt(int src, int seq, int dest);
      logic [TW-1:0] p = '0;
      p[1:0]     = dest[1:0];
      p[2 +: 32] = seq;
      p[34 +: 32] = src;
      return p;
   endfunction

   function automatic logic [15:0] lfsr_step(logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic int rand_dest(int src, logic [15:0] v);
      int d;
      d = v[1:0];
      return (d == src) ? (src + 1) % 4 : d;
   endfunction

   // Ideal NoC: each destination accepts one queued packet per cycle.
   task automatic noc_deliver();
      logic [3:0] v = '0;
      int src;
      for (int d = 0; d < 4; d++) begin
         if (q[d].size() > 0) begin
            src = q[d].pop_front();
            v[d] = 1'b1;
            wd_a[d*TW +: TW] = exp_pkt(src, 0, d);
            m_recv[d]++;
         end
      end
      wv_a = v;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start_a = 1'b1; start_b = 1'b1; en_a = 4'hF; en_b = 4'hF;
      rdy_a = 4'hF; rdy_b = 4'hF; wv_a = 4'hF; wv_b = 4'hF; wd_a = '0; wd_b = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rv_a !== 4'h0 || rv_b !== 4'h0 || rd_a !== '0 || rd_b !== '0) begin
            errors++; $display("FAIL reset_valid c=%0d got a=%h b=%h exp 0", c, rv_a, rv_b);
         end
         checks++;
         if (done_a !== 1'b0 || done_b !== 1'b0) begin
            errors++; $display("FAIL reset_done c=%0d got a=%b b=%b exp 0", c, done_a, done_b);
         end
         checks++;
         if (rc_a !== '0 || rc_b !== '0) begin
            errors++; $display("FAIL reset_rcount c=%0d got a=%h b=%h exp 0", c, rc_a, rc_b);
         end
      end
      start_b = 1'b0; wv_a = 4'h0; wv_b = 4'h0;
   endtask

   task automatic run_traffic(input logic [3:0] en, input int stall0, input bit rnd, input int ncyc);
      logic [1:0]    hist = 2'b00;
      bit            all;
      bit            ev;
      int            d, sum, nen;
      logic [TW-1:0] exp;
      @(negedge clk);
      rstn = 1'b0; start_a = 1'b0; wv_a = 4'h0;
      for (int i = 0; i < 4; i++) begin
         m_sent[i] = 0; m_recv[i] = 0; m_lfsr[i] = 16'(i + 1); q[i].delete();
      end
      @(negedge clk);
      rstn = 1'b1; start_a = 1'b1; en_a = en; rdy_a = (stall0 > 0) ? 4'b1110 : 4'hF;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         checks++;
         if (done_a !== hist[1]) begin
            errors++; $display("FAIL done c=%0d got=%b exp=%b", c, done_a, hist[1]);
         end
         if (rnd) rdy_a = 4'($urandom);
         else     rdy_a = (c < stall0) ? 4'b1110 : 4'hF;
         noc_deliver();
         for (int i = 0; i < 4; i++) begin
            ev = en[i] && (m_sent[i] < NP);
            checks++;
            if (rv_a[i] !== ev) begin
               errors++; $display("FAIL valid pe=%0d c=%0d got=%b exp=%b", i, c, rv_a[i], ev);
            end
            if (rv_a[i] === 1'b1 && ev) begin
               d = rand_dest(i, m_lfsr[i]);
               exp = exp_pkt(i, m_sent[i], d);
               checks++;
               if (rd_a[i*TW +: TW] !== exp) begin
                  errors++;
                  $display("FAIL data pe=%0d c=%0d got=%h exp=%h", i, c, rd_a[i*TW +: TW], exp);
               end
               if (rdy_a[i]) begin
                  checks++;
                  if (rd_a[i*TW +: 2] === 2'(i)) begin
                     errors++; $display("FAIL self_addr pe=%0d got dest=%0d exp other", i, rd_a[i*TW +: 2]);
                  end
                  q[d].push_back(i);
                  m_sent[i]++;
                  m_lfsr[i] = lfsr_step(m_lfsr[i]);
               end
            end
         end
         all = 1'b1;
         for (int i = 0; i < 4; i++)
            if (en[i] && m_sent[i] != NP) all = 1'b0;
         hist = {hist[0], all};
      end
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         noc_deliver();
      end
      @(negedge clk);
      sum = 0; nen = 0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rc_a[i*32 +: 32] !== 32'(m_recv[i])) begin
            errors++; $display("FAIL rcount pe=%0d got=%0d exp=%0d", i, rc_a[i*32 +: 32], m_recv[i]);
         end
         sum += int'(rc_a[i*32 +: 32]);
         if (en[i]) nen++;
      end
      checks++;
      if (sum != nen * NP) begin
         errors++; $display("FAIL rcount_sum got=%0d exp=%0d", sum, nen * NP);
      end
      checks++;
      if (done_a !== 1'b1) begin
         errors++; $display("FAIL done_final got=%b exp=1", done_a);
      end
   endtask

   task automatic test_back_to_back();
      run_traffic(4'hF, 0, 1'b0, 10);
   endtask

   task automatic test_stall();
      run_traffic(4'hF, 10, 1'b0, 20);
   endtask

   task automatic test_enable_mask();
      run_traffic(4'b0101, 0, 1'b0, 10);
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++)
         run_traffic(4'($urandom_range(1, 15)), 0, 1'b1, 40);
   endtask

   task automatic test_midreset();
      @(negedge clk);
      rstn = 1'b0; start_a = 1'b0;
      @(negedge clk);
      rstn = 1'b1; start_a = 1'b1; en_a = 4'hF; rdy_a = 4'h0; wv_a = 4'hF;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (rv_a !== 4'h0 || rd_a !== '0) begin
         errors++; $display("FAIL midreset_valid got=%h exp=0", rv_a);
      end
      checks++;
      if (rc_a !== '0 || done_a !== 1'b0) begin
         errors++; $display("FAIL midreset_state got rc=%h done=%b exp 0", rc_a, done_a);
      end
      rstn = 1'b1; start_a = 1'b0; wv_a = 4'h0;
   endtask

   task automatic test_rate();
      int last[4];
      int cnt[4];
      int d;
      @(negedge clk);
      rstn = 1'b0; start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin last[i] = -1; cnt[i] = 0; end
      @(negedge clk);
      rstn = 1'b1; start_b = 1'b1; en_b = 4'hF; rdy_b = 4'hF;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rv_b[i] === 1'b1) begin
               checks++;
               if (cnt[i] >= NP || (last[i] < 0 && c != 0) || (last[i] >= 0 && c - last[i] != 3)) begin
                  errors++;
                  $display("FAIL rate_gap pe=%0d c=%0d got gap=%0d exp=3 (n=%0d)", i, c, c - last[i], cnt[i]);
               end
               d = (i / 2) * 2 + ((i % 2) ^ 1);
               checks++;
               if (rd_b[i*TW +: TW] !== exp_pkt(i, cnt[i], d)) begin
                  errors++;
                  $display("FAIL nb_data pe=%0d got=%h exp=%h", i, rd_b[i*TW +: TW], exp_pkt(i, cnt[i], d));
               end
               cnt[i]++;
               last[i] = c;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (cnt[i] != NP) begin
            errors++; $display("FAIL rate_count pe=%0d got=%0d exp=%0d", i, cnt[i], NP);
         end
      end
      checks++;
      if (done_b !== 1'b1) begin
         errors++; $display("FAIL rate_done got=%b exp=1", done_b);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_enable_mask();
      test_random();
      test_midreset();
      test_rate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
